jtag_host_shifter: RTL and testbench



---
 rtl/jtag_host_shifter.sv | 199 +++++++++++++++++++
 tb/tb_jtag_host_shifter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_shifter.sv
`timescale 1ns/1ps
// jtag_host_shifter
//   Host-side JTAG scan driver. Takes IR/DR scan or TAP-reset commands over a
//   valid/ready handshake. It walks the TAP through the scan one TCK at a time
//   by driving TMS/TDI. It samples TDO during the shift and returns the
//   captured bits.
//
//   Host state X means the TAP is currently in X. The registered o_tms/o_tdi
//   are the values the TAP samples on the posedge that leaves X.
//
// Ports
//   i_tclk      TCK; every state update happens on its rising edge
//   i_trst_n    asynchronous reset, active HIGH (asserted = 1)
//   i_cmdValid  command present         o_cmdReady  command can be accepted
//   i_cmdTlr    command is a TAP reset  i_cmdIr     1 = IR scan, 0 = DR scan
//   i_cmdLen    scan length in bits     i_cmdData   TDI bits, LSB first
//   o_tms/o_tdi to the TAP              i_tdo       from the TAP
//   o_rspValid  one-cycle pulse when a scan completes
//   o_rspData   captured TDO bits, right-aligned, upper bits zero
//   o_busy      host is not idle
//
// Configuration
//   JTAG_HOST_TLR_ON_RESET_EN: when defined, the host resets the TAP by itself
//   after reset deassertion (5 x TMS=1, then TMS=0) before it accepts commands.
module jtag_host_shifter #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               i_tclk,
    input  logic               i_trst_n,
    input  logic               i_cmdValid,
    output logic               o_cmdReady,
    input  logic               i_cmdTlr,
    input  logic               i_cmdIr,
    input  logic [LEN_W-1:0]   i_cmdLen,
    input  logic [MAX_LEN-1:0] i_cmdData,
    output logic               o_tms,
    output logic               o_tdi,
    input  logic               i_tdo,
    output logic               o_rspValid,
    output logic [MAX_LEN-1:0] o_rspData,
    output logic               o_busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_SEL_DR, ST_SEL_IR, ST_CAPTURE, ST_SHIFT,
        ST_EXIT1, ST_UPDATE, ST_TLR, ST_TLR_RTI, ST_BOOT
    } state_t;

`ifdef JTAG_HOST_TLR_ON_RESET_EN
    localparam state_t ST_RESET = ST_BOOT;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    // Five TMS=1 cycles reach Test-Logic-Reset from any TAP state.
    localparam logic [2:0] TLR_LAST = 3'd4;

    function automatic logic [LEN_W-1:0] f_clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_W'(1);
        else if (len > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return len;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [2:0]         r_tlrCnt;
    logic [2:0]         w_tlrCnt_nxt;
    logic               r_tms;
    logic               r_tdi;
    logic               w_tms_nxt;
    logic               w_tdi_nxt;
    logic               r_rspValid;
    logic [MAX_LEN-1:0] r_rspData;
    logic               r_ir;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] w_shiftData;
    logic               w_accept;
    logic               w_lastBit;

    // The response pulse blocks acceptance, so a command never starts in the
    // cycle a response is emitted.
    assign o_cmdReady = (r_state == ST_IDLE) && !r_rspValid;
    assign w_accept   = i_cmdValid && o_cmdReady;
    assign w_lastBit  = (r_cnt == r_len - LEN_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_tlrCnt_nxt = r_tlrCnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_cmdTlr) begin
                        w_state_nxt  = ST_TLR;
                        w_tlrCnt_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_START;
                    end
                end
            end
            ST_START:   w_state_nxt = ST_SEL_DR;
            ST_SEL_DR:  w_state_nxt = r_ir ? ST_SEL_IR : ST_CAPTURE;
            ST_SEL_IR:  w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = '0;
            end
            ST_SHIFT: begin
                if (w_lastBit)
                    w_state_nxt = ST_EXIT1;
                else
                    w_cnt_nxt   = r_cnt + LEN_W'(1);
            end
            ST_EXIT1:   w_state_nxt = ST_UPDATE;
            ST_UPDATE:  w_state_nxt = ST_IDLE;
            ST_TLR: begin
                if (r_tlrCnt == TLR_LAST)
                    w_state_nxt  = ST_TLR_RTI;
                else
                    w_tlrCnt_nxt = r_tlrCnt + 3'd1;
            end
            ST_TLR_RTI: w_state_nxt = ST_IDLE;
            ST_BOOT: begin
                w_state_nxt  = ST_TLR;
                w_tlrCnt_nxt = '0;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // TMS/TDI are derived from the state being entered, so the registered pins
    // hold the value the TAP samples at the end of that state.
    assign w_shiftData = r_data >> w_cnt_nxt;

    always_comb begin
        w_tms_nxt = 1'b0;
        w_tdi_nxt = 1'b0;
        case (w_state_nxt)
            ST_START:  w_tms_nxt = 1'b1;
            ST_SEL_DR: w_tms_nxt = r_ir;
            ST_SHIFT: begin
                w_tms_nxt = (w_cnt_nxt == r_len - LEN_W'(1));
                w_tdi_nxt = w_shiftData[0];
            end
            ST_EXIT1:  w_tms_nxt = 1'b1;
            ST_TLR:    w_tms_nxt = 1'b1;
            default:   w_tms_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_tclk or posedge i_trst_n) begin
        if (i_trst_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_tlrCnt   <= '0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tlrCnt   <= w_tlrCnt_nxt;
            r_tms      <= w_tms_nxt;
            r_tdi      <= w_tdi_nxt;
            r_rspValid <= (r_state == ST_UPDATE);
            if (r_state == ST_UPDATE)
                r_rspData <= r_cap;
        end
    end

    // Command fields and the capture buffer need no reset: they are always
    // loaded on acceptance before any scan state reads them.
    always_ff @(posedge i_tclk) begin
        if (w_accept && !i_cmdTlr) begin
            r_ir   <= i_cmdIr;
            r_len  <= f_clamp_len(i_cmdLen);
            r_data <= i_cmdData;
            r_cap  <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_cap  <= r_cap | ({{(MAX_LEN-1){1'b0}}, i_tdo} << r_cnt);
        end
    end

    assign o_tms      = r_tms;
    assign o_tdi      = r_tdi;
    assign o_rspValid = r_rspValid;
    assign o_rspData  = r_rspData;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jtag_host_shifter.sv
`timescale 1ns/1ps
module tb_jtag_host_shifter;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmdValid = 1'b0;
    logic               cmdReady;
    logic               cmdTlr = 1'b0;
    logic               cmdIr = 1'b0;
    logic [LEN_W-1:0]   cmdLen = '0;
    logic [MAX_LEN-1:0] cmdData = '0;
    logic               tms, tdi, tdo;
    logic               rspValid;
    logic [MAX_LEN-1:0] rspData;
    logic               busy;

    always #5 clk = ~clk;

    jtag_host_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .i_tclk(clk), .i_trst_n(rst), .i_cmdValid(cmdValid), .o_cmdReady(cmdReady),
        .i_cmdTlr(cmdTlr), .i_cmdIr(cmdIr), .i_cmdLen(cmdLen), .i_cmdData(cmdData),
        .o_tms(tms), .o_tdi(tdi), .i_tdo(tdo), .o_rspValid(rspValid),
        .o_rspData(rspData), .o_busy(busy)
    );

    // ---------------- reference TAP (IEEE 1149.1 state diagram) ----------------
    typedef enum int {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_t;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    typedef struct { logic [31:0] data; int lat; int acc; } rsp_t;
    typedef struct { logic [31:0] data; int len; } upd_t;
    rsp_t exp_q[$];
    upd_t upd_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cap_idx = 0;
    int scan_idx = 0;
    int tlr_cnt = 0;
    int last_rsp_cyc = 0;
    logic [31:0] cap_val [0:255];
    tap_t        tap = T_TLR;
    logic [31:0] tap_sr = '0;
    logic        tap_bits[$];

    assign tdo = (tap == T_SHDR || tap == T_SHIR) ? tap_sr[0] : 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int efflen(int l);
        if (l == 0) return 1;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    function automatic logic [31:0] lenmask(int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // The TAP shares the host reset so an aborted scan leaves both ends in step.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tap <= T_TLR;
            tap_bits.delete();
        end else begin
            if (tap == T_CAPDR || tap == T_CAPIR) begin
                tap_sr <= cap_val[cap_idx % 256];
                cap_idx++;
            end else if (tap == T_SHDR || tap == T_SHIR) begin
                tap_sr <= {tdi, tap_sr[31:1]};
                tap_bits.push_back(tdi);
            end
            if (tap != T_TLR && tap_next(tap, tms) == T_TLR) tlr_cnt++;
            tap <= tap_next(tap, tms);
        end
    end

    // Monitor: TAP-side update contents and host-side responses.
    always @(negedge clk) begin
        if (!rst) begin
            if (tap != T_SHDR && tap != T_SHIR && tdi !== 1'b0)
                chk("tdi_outside_shift", 64'(tdi), 64'd0);
            if (tap == T_UPDR || tap == T_UPIR) begin
                logic [31:0] v;
                upd_t u;
                v = '0;
                for (int i = 0; i < tap_bits.size() && i < 32; i++) v[i] = tap_bits[i];
                if (upd_q.size() == 0) begin
                    chk("unexpected_update", 64'd1, 64'd0);
                end else begin
                    u = upd_q.pop_front();
                    chk("update_len", 64'(tap_bits.size()), 64'(u.len));
                    chk("update_data", 64'(v), 64'(u.data));
                end
                tap_bits.delete();
            end
            if (rspValid) begin
                rsp_t r;
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_data", 64'(rspData), 64'(r.data));
                    chk("rsp_latency", 64'(cyc - r.acc), 64'(r.lat));
                end
            end
        end
    end

    task automatic issue(input bit tlr, input bit ir, input int len,
                         input logic [31:0] data, output int acc);
        int t;
        int eff;
        rsp_t r;
        upd_t u;
        @(negedge clk);
        cmdValid = 1'b1;
        cmdTlr   = tlr;
        cmdIr    = ir;
        cmdLen   = LEN_W'(len);
        cmdData  = data;
        t = 0;
        while (!cmdReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmdReady) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cmdValid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (!tlr) begin
            eff    = efflen(len);
            r.data = cap_val[scan_idx % 256] & lenmask(eff);
            r.lat  = eff + (ir ? 6 : 5);
            r.acc  = acc;
            u.data = data & lenmask(eff);
            u.len  = eff;
            exp_q.push_back(r);
            upd_q.push_back(u);
            scan_idx++;
        end
        @(posedge clk);
        #1 cmdValid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && cmdReady) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, t0, t;
        for (int i = 0; i < 256; i++) cap_val[i] = $urandom;
        cap_val[0] = 32'h1234_56A5;   // DR scan returns 0xA5 in its low byte
        cap_val[1] = 32'h0000_0005;   // IR capture pattern 0b0101

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tms", 64'(tms), 64'd0);
        chk("reset_tdi", 64'(tdi), 64'd0);
        chk("reset_rspValid", 64'(rspValid), 64'd0);
        chk("reset_rspData", 64'(rspData), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
`ifndef JTAG_HOST_TLR_ON_RESET_EN
        chk("ready_after_reset", 64'(cmdReady), 64'd1);
`endif

        issue(0, 0, 8, 32'hA5, acc);        // DR len 8
        wait_idle();
        issue(0, 1, 4, 32'h3, acc);         // IR len 4
        wait_idle();

        t0 = tlr_cnt;                       // TAP reset command
        issue(1, 0, 0, 32'h0, acc);
        t = 0;
        while (!cmdReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("tlr_latency", 64'(cyc - acc), 64'd6);
        chk("tlr_reached", 64'(tlr_cnt - t0), 64'd1);
        chk("tlr_tap_rti", 64'(tap), 64'(T_RTI));

        issue(0, 0, 0, 32'hFFFF_FFFF, acc); // len 0 -> 1 bit
        issue(0, 0, 40, $urandom, acc);     // len 40 -> 32 bits
        wait_idle();

        issue(0, 0, 8, $urandom, acc);      // reset during shift bit 3
        t = 0;
        while (!(tap == T_SHDR && tap_bits.size() == 3) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reached_shift_bit3", 64'(tap_bits.size()), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("abort_tms", 64'(tms), 64'd0);
        chk("abort_tdi", 64'(tdi), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rspValid", 64'(rspValid), 64'd0);
        chk("abort_rspData", 64'(rspData), 64'd0);
        exp_q.delete();
        upd_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(0, 0, 12, $urandom, acc);
        wait_idle();

        issue(0, 0, 6, $urandom, acc);      // back-to-back pair
        issue(0, 0, 9, $urandom, acc2);
        // Response pulse cycle, then one idle cycle, then the accepting edge.
        chk("b2b_accept_gap", 64'(acc2 - last_rsp_cyc), 64'd2);
        wait_idle();

        for (int n = 0; n < 40; n++)
            issue(($urandom % 8) == 0, $urandom % 2, $urandom_range(0, 40), $urandom, acc);
        wait_idle();
        chk("queues_drained", 64'(exp_q.size() + upd_q.size()), 64'd0);
        chk("final_tap_rti", 64'(tap), 64'(T_RTI));
        chk("final_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
